// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the load/store memory access controller: access-size encodings and FSM states.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WRITE     = 3'd2,
        RMW_READ  = 3'd3,
        RMW_WRITE = 3'd4,
        DONE      = 3'd5
    } state_e;

    // Size code 2'b11 is handled exactly like a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response channel plus memory bus of the load/store controller.
// A request transfers in a cycle where req_valid and req_ready are both high;
// rsp_valid is a single-cycle pulse and cannot be back-pressured.
interface mem_access_ctrl_if #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [1:0]              req_size;
    logic                    req_signed;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [8*BYTE_SIZE-1:0]  req_wdata;
    logic                    rsp_valid;
    logic [8*BYTE_SIZE-1:0]  rsp_rdata;
    logic                    rsp_err;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_we;
    logic [8*BYTE_SIZE-1:0]  mem_wd;
    logic [8*BYTE_SIZE-1:0]  mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wd
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wd
    );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational lane logic: load lane extraction with zero/sign extension,
// and merge of sub-word store data into lane 0 (byte) or lanes 0-1 (half).
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int BYTE_SIZE = 4
) (
    input  logic [1:0]             size_i,
    input  logic                   signed_i,
    input  logic [8*BYTE_SIZE-1:0] rd_word_i,
    input  logic [8*BYTE_SIZE-1:0] merge_word_i,
    input  logic [8*BYTE_SIZE-1:0] wdata_i,
    output logic [8*BYTE_SIZE-1:0] load_data_o,
    output logic [8*BYTE_SIZE-1:0] store_data_o
);

    always_comb begin
        load_data_o  = rd_word_i;
        store_data_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o  = {{(8*BYTE_SIZE-8){signed_i & rd_word_i[7]}}, rd_word_i[7:0]};
                store_data_o = {merge_word_i[8*BYTE_SIZE-1:8], wdata_i[7:0]};
            end
            SZ_HALF: begin
                load_data_o  = {{(8*BYTE_SIZE-16){signed_i & rd_word_i[15]}}, rd_word_i[15:0]};
                store_data_o = {merge_word_i[8*BYTE_SIZE-1:16], wdata_i[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the memory stage and a combinational-read, synchronous-write memory.
// Optional alignment check enabled by defining MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    mem_access_ctrl_if.slave    bus,
    output state_e              dbg_state_o
);

    localparam int DW = 8 * BYTE_SIZE;

    state_e                state_q, state_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [DW-1:0]         merge_q, merge_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic [DW-1:0]         load_data, store_data, mem_wd;
    logic                  mem_we_raw, req_ready;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic                  err_q, err_d;
    logic                  misaligned;
`endif

    mem_lane_align #(.BYTE_SIZE(BYTE_SIZE)) u_lane_align (
        .size_i       (size_q),
        .signed_i     (signed_q),
        .rd_word_i    (bus.mem_rd),
        .merge_word_i (merge_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_data_o (store_data)
    );

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign misaligned = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                        (is_word(bus.req_size) && (bus.req_addr[1:0] != 2'b00));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        signed_d   = signed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        req_ready  = 1'b0;
        mem_we_raw = 1'b0;
        mem_wd     = '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    if (!bus.req_we)                 state_d = READ;
                    else if (is_word(bus.req_size))  state_d = WRITE;
                    else                             state_d = RMW_READ;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                    err_d = misaligned;
                    // A misaligned request skips the memory entirely and reports an error.
                    if (misaligned) begin
                        state_d = DONE;
                        rdata_d = '0;
                    end
`endif
                end
            end
            READ: begin
                rdata_d = load_data;
                state_d = DONE;
            end
            WRITE: begin
                mem_wd     = wdata_q;
                mem_we_raw = 1'b1;
                rdata_d    = '0;
                state_d    = DONE;
            end
            RMW_READ: begin
                merge_d = bus.mem_rd;
                state_d = RMW_WRITE;
            end
            RMW_WRITE: begin
                mem_wd     = store_data;
                mem_we_raw = 1'b1;
                rdata_d    = '0;
                state_d    = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write enable is gated by reset so an aborted RMW never reaches the memory.
    assign bus.mem_we    = mem_we_raw & ~reset;
    assign bus.mem_wd    = mem_wd;
    assign bus.mem_addr  = addr_q;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_rdata = rdata_q;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign bus.rsp_err   = err_q & (state_q == DONE);
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-array memory model (combinational read, posedge write).
// Alignment-error expectations follow MEM_ACCESS_ALIGN_CHECK_EN.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic preload;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.BYTE_SIZE(4), .ADDR_WIDTH(32)) bus ();
    state_e dbg_state;

    mem_access_ctrl #(.BYTE_SIZE(4), .ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    logic [7:0] mem [0:255];
    logic [7:0] ma;
    int         we_cnt = 0;
    int         checks = 0;
    int         errors = 0;

    assign ma         = bus.mem_addr[7:0];
    assign bus.mem_rd = {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)], mem[8'(ma + 8'd1)], mem[ma]};

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'h80;
            mem[8'h11] <= 8'h7F;
            mem[8'h12] <= 8'h01;
            mem[8'h13] <= 8'hFF;
        end else if (bus.mem_we) begin
            for (int i = 0; i < 4; i++) mem[8'(ma + 8'(i))] <= bus.mem_wd[8*i +: 8];
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

    // Returns cycles since acceptance; an expired bound yields a latency no check expects.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        reset = 1'b1; preload = 1'b1;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state act=%0d exp=%0d", dbg_state, IDLE); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid act=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata act=%h exp=0", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err act=%b exp=0", bus.rsp_err); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr act=%h exp=0", bus.mem_addr); end
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_wd !== 32'h0) begin errors++; $display("FAIL rst_mem_we_wd act=%b/%h exp=0/0", bus.mem_we, bus.mem_wd); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready act=%b exp=1", bus.req_ready); end
    endtask

    typedef struct {
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] exp;
    } ld_vec_t;

    task automatic test_load();
        ld_vec_t lv [9];
        int lat;
        lv = '{
            '{SZ_BYTE, 1'b1, 32'h10, 32'hFFFFFF80},
            '{SZ_BYTE, 1'b0, 32'h10, 32'h00000080},
            '{SZ_HALF, 1'b1, 32'h10, 32'h00007F80},
            '{SZ_HALF, 1'b0, 32'h12, 32'h0000FF01},
            '{SZ_HALF, 1'b1, 32'h12, 32'hFFFFFF01},
            '{SZ_WORD, 1'b0, 32'h10, 32'hFF017F80},
            '{2'b11,   1'b1, 32'h10, 32'hFF017F80},
            '{SZ_BYTE, 1'b1, 32'h11, 32'h0000007F},
            '{SZ_BYTE, 1'b1, 32'h13, 32'hFFFFFFFF}
        };
        foreach (lv[i]) begin
            issue(1'b0, lv[i].size, lv[i].sgn, lv[i].addr, 32'h0);
            checks++; if (bus.mem_addr !== lv[i].addr) begin errors++; $display("FAIL ld%0d_mem_addr act=%h exp=%h", i, bus.mem_addr, lv[i].addr); end
            wait_rsp(lat);
            checks++; if (lat != 2) begin errors++; $display("FAIL ld%0d_latency act=%0d exp=2", i, lat); end
            checks++; if (bus.rsp_rdata !== lv[i].exp) begin errors++; $display("FAIL ld%0d_rdata act=%h exp=%h", i, bus.rsp_rdata, lv[i].exp); end
            checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL ld%0d_err act=%b exp=0", i, bus.rsp_err); end
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== lv[i].exp) begin errors++; $display("FAIL ld%0d_after act=%b/%h exp=0/%h", i, bus.rsp_valid, bus.rsp_rdata, lv[i].exp); end
        end
    endtask

    task automatic test_word_store();
        int lat, w0;
        w0 = we_cnt;
        issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hDEADBEEF);
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h20 || bus.mem_wd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_t1 act=%b/%h/%h exp=1/00000020/deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wd); end
        wait_rsp(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency act=%0d exp=2", lat); end
        checks++; if (bus.rsp_rdata !== 32'h0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL sw_rsp act=%h/%b exp=0/0", bus.rsp_rdata, bus.mem_we); end
        checks++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL sw_we_count act=%0d exp=1", we_cnt - w0); end
        issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
        wait_rsp(lat);
        checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_readback act=%h exp=deadbeef", bus.rsp_rdata); end
    endtask

    task automatic test_subword_store();
        int lat, w0;
        w0 = we_cnt;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h20, 32'h000000AA);
        checks++; if (bus.mem_we !== 1'b0 || dbg_state !== RMW_READ) begin errors++; $display("FAIL sb_t1 act=%b/%0d exp=0/%0d", bus.mem_we, dbg_state, RMW_READ); end
        @(negedge clk);
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_wd !== 32'hDEADBEAA) begin errors++; $display("FAIL sb_t2 act=%b/%h exp=1/deadbeaa", bus.mem_we, bus.mem_wd); end
        wait_rsp(lat);
        checks++; if (lat + 1 != 3) begin errors++; $display("FAIL sb_latency act=%0d exp=3", lat + 1); end
        checks++; if (bus.rsp_rdata !== 32'h0 || we_cnt - w0 != 1) begin errors++; $display("FAIL sb_rsp act=%h/%0d exp=0/1", bus.rsp_rdata, we_cnt - w0); end
        issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
        wait_rsp(lat);
        checks++; if (bus.rsp_rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL sb_readback act=%h exp=deadbeaa", bus.rsp_rdata); end
        // Halfword at 0x22 overwrites bytes 0x22-0x23 only; upper wdata bits must be ignored.
        issue(1'b1, SZ_HALF, 1'b0, 32'h22, 32'hFFFF1234);
        @(negedge clk);
        checks++; if (bus.mem_wd !== 32'h00001234) begin errors++; $display("FAIL sh_merge act=%h exp=00001234", bus.mem_wd); end
        wait_rsp(lat);
        issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
        wait_rsp(lat);
        checks++; if (bus.rsp_rdata !== 32'h1234BEAA) begin errors++; $display("FAIL sh_readback act=%h exp=1234beaa", bus.rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = SZ_WORD;
        bus.req_signed = 1'b0; bus.req_addr = 32'h10;
        @(negedge clk);
        bus.req_size = SZ_BYTE; bus.req_addr = 32'h11;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_t1 act=%b exp=0", bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hFF017F80 || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_first act=%b/%h/%b exp=1/ff017f80/0", bus.rsp_valid, bus.rsp_rdata, bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_ready_t3 act=%b/%b exp=1/0", bus.req_ready, bus.rsp_valid); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (dbg_state !== READ || bus.mem_addr !== 32'h11) begin errors++; $display("FAIL b2b_second_accept act=%0d/%h exp=%0d/00000011", dbg_state, bus.mem_addr, READ); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0000007F) begin errors++; $display("FAIL b2b_second act=%b/%h exp=1/0000007f", bus.rsp_valid, bus.rsp_rdata); end
    endtask

    task automatic test_reset_abort();
        int w0;
        w0 = we_cnt;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h20, 32'h00000055);
        @(negedge clk);
        checks++; if (dbg_state !== RMW_WRITE || bus.mem_we !== 1'b1) begin errors++; $display("FAIL abort_pre act=%0d/%b exp=%0d/1", dbg_state, bus.mem_we, RMW_WRITE); end
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL abort_we_gate act=%b exp=0", bus.mem_we); end
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_next act=%b/%b exp=1/0", bus.req_ready, bus.rsp_valid); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_rsp act=%b exp=0", bus.rsp_valid); end
        checks++; if (we_cnt - w0 != 0 || mem[8'h20] !== 8'hAA) begin errors++; $display("FAIL abort_mem act=%0d/%h exp=0/aa", we_cnt - w0, mem[8'h20]); end
    endtask

    task automatic test_align();
        int lat, w0;
        w0 = we_cnt;
        issue(1'b1, SZ_WORD, 1'b0, 32'h21, 32'hCAFEF00D);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL al_sw_err act=%b/%b/%h exp=1/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        @(negedge clk);
        checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL al_err_clear act=%b/%b exp=0/0", bus.rsp_err, bus.rsp_valid); end
        checks++; if (we_cnt - w0 != 0 || mem[8'h21] !== 8'hBE) begin errors++; $display("FAIL al_no_write act=%0d/%h exp=0/be", we_cnt - w0, mem[8'h21]); end
        issue(1'b0, SZ_HALF, 1'b1, 32'h11, 32'h0);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL al_lh_err act=%b/%b/%h exp=1/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        @(negedge clk);
`else
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h21) begin errors++; $display("FAIL al_sw_write act=%b/%h exp=1/00000021", bus.mem_we, bus.mem_addr); end
        wait_rsp(lat);
        checks++; if (lat != 2 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL al_sw_rsp act=%0d/%b exp=2/0", lat, bus.rsp_err); end
        checks++; if (mem[8'h21] !== 8'h0D || mem[8'h24] !== 8'hCA) begin errors++; $display("FAIL al_sw_mem act=%h/%h exp=0d/ca", mem[8'h21], mem[8'h24]); end
        issue(1'b0, SZ_WORD, 1'b0, 32'h21, 32'h0);
        wait_rsp(lat);
        checks++; if (bus.rsp_rdata !== 32'hCAFEF00D || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL al_readback act=%h/%b exp=cafef00d/0", bus.rsp_rdata, bus.rsp_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_word_store();
        test_subword_store();
        test_back_to_back();
        test_reset_abort();
        test_align();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
